// File: rtl/ascon_io_ctrl_pkg.sv
// Shared types and constants for the host-side ASCON-128 I/O sequencer.
package ascon_io_ctrl_pkg;

  localparam int unsigned ASCON_BLOCK_W    = 64;
  localparam int unsigned ASCON_TAG_W      = 128;
  localparam int unsigned DEF_N_PT         = 4;
  localparam int unsigned DEF_INIT_CYCLES  = 16;
  localparam int unsigned DEF_BLOCK_CYCLES = 16;
  localparam int unsigned DEF_TIMEOUT      = 64;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StGap,
    StLoad,
    StIssue,
    StWaitTag,
    StTagOut
  } io_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascon_io_ctrl_if.sv
// Host and core facing signals of the sequencer; slave is the sequencer's view.
interface ascon_io_ctrl_if;
  import ascon_io_ctrl_pkg::*;

  logic                     start_req_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [ASCON_BLOCK_W-1:0] in_data_i;
  logic                     start_o;
  logic                     data_valid_o;
  logic [ASCON_BLOCK_W-1:0] data_o;
  logic                     cipher_valid_i;
  logic [ASCON_BLOCK_W-1:0] cipher_i;
  logic                     end_i;
  logic [ASCON_TAG_W-1:0]   tag_i;
  logic                     ct_valid_o;
  logic                     ct_ready_i;
  logic [ASCON_BLOCK_W-1:0] ct_data_o;
  logic                     tag_valid_o;
  logic                     tag_ready_i;
  logic [ASCON_TAG_W-1:0]   tag_o;
  logic                     busy_o;
  logic                     error_o;

  modport slave (
    input  start_req_i, in_valid_i, in_data_i, cipher_valid_i, cipher_i, end_i, tag_i,
           ct_ready_i, tag_ready_i,
    output in_ready_o, start_o, data_valid_o, data_o, ct_valid_o, ct_data_o, tag_valid_o,
           tag_o, busy_o, error_o
  );

  modport master (
    output start_req_i, in_valid_i, in_data_i, cipher_valid_i, cipher_i, end_i, tag_i,
           ct_ready_i, tag_ready_i,
    input  in_ready_o, start_o, data_valid_o, data_o, ct_valid_o, ct_data_o, tag_valid_o,
           tag_o, busy_o, error_o
  );

endinterface

// File: rtl/ascon_io_ctrl_ct_fifo.sv
// Two-entry ciphertext FIFO; push and pop may coincide, even when full.
module ascon_io_ctrl_ct_fifo
  import ascon_io_ctrl_pkg::*;
(
  input  logic                     clock_i,
  input  logic                     resetb_i,
  input  logic                     push_i,
  input  logic [ASCON_BLOCK_W-1:0] data_i,
  input  logic                     pop_i,
  output logic [ASCON_BLOCK_W-1:0] data_o,
  output logic                     full_o,
  output logic                     empty_o
);

  logic [ASCON_BLOCK_W-1:0] mem_q [2];
  logic                     wr_q, rd_q;
  logic [1:0]               cnt_q;
  logic                     do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ascon_io_ctrl.sv
// Host-side sequencer pacing AD + plaintext blocks into the ASCON core and
// returning ciphertext blocks and the tag over valid/ready.
module ascon_io_ctrl
  import ascon_io_ctrl_pkg::*;
#(
  parameter int unsigned N_PT         = DEF_N_PT,
  parameter int unsigned INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int unsigned BLOCK_CYCLES = DEF_BLOCK_CYCLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input logic            clock_i,
  input logic            resetb_i,
  ascon_io_ctrl_if.slave io
);

  localparam int unsigned CntW =
      $clog2(max_u(max_u(INIT_CYCLES, BLOCK_CYCLES), TIMEOUT) + 1);

  io_state_t                state_q;
  logic [CntW-1:0]          cnt_q;
  logic [3:0]               idx_q;
  logic                     start_q, dv_q, in_ready_q, busy_q, error_q, tag_valid_q, cv_q;
  logic [ASCON_BLOCK_W-1:0] data_q;
  logic [ASCON_TAG_W-1:0]   tag_q;
  logic                     ct_pop, ct_full, ct_empty;

  assign ct_pop = ~ct_empty & io.ct_ready_i;

  ascon_io_ctrl_ct_fifo u_ct_fifo (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .push_i   (cv_q),
    .data_i   (io.cipher_i),
    .pop_i    (ct_pop),
    .data_o   (io.ct_data_o),
    .full_o   (ct_full),
    .empty_o  (ct_empty)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      start_q     <= 1'b0;
      dv_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      tag_valid_q <= 1'b0;
      cv_q        <= 1'b0;
      data_q      <= '0;
      tag_q       <= '0;
    end else begin
      // cipher_i is a held register in the core, so it is captured one cycle after the pulse
      cv_q <= io.cipher_valid_i & (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (io.start_req_i) begin
            error_q <= 1'b0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          start_q <= 1'b0;
          idx_q   <= '0;
          cnt_q   <= CntW'(INIT_CYCLES);
          state_q <= StGap;
        end
        StGap: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (!ct_full) begin
            in_ready_q <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          if (io.in_valid_i) begin
            data_q     <= io.in_data_i;
            in_ready_q <= 1'b0;
            dv_q       <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          dv_q  <= 1'b0;
          idx_q <= idx_q + 4'd1;
          if (32'(idx_q) < N_PT) begin
            cnt_q   <= CntW'(BLOCK_CYCLES);
            state_q <= StGap;
          end else begin
            // The ISSUE cycle already counts toward the timeout window
            cnt_q   <= CntW'(TIMEOUT - 1);
            state_q <= StWaitTag;
          end
        end
        StWaitTag: begin
          if (io.end_i) begin
            tag_q       <= io.tag_i;
            tag_valid_q <= 1'b1;
            state_q     <= StTagOut;
          end else if (cnt_q <= CntW'(1)) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StTagOut: begin
          if (io.tag_ready_i) tag_valid_q <= 1'b0;
          if ((!tag_valid_q || io.tag_ready_i) && ct_empty) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io.start_o      = start_q;
  assign io.data_valid_o = dv_q;
  assign io.data_o       = data_q;
  assign io.in_ready_o   = in_ready_q;
  assign io.ct_valid_o   = ~ct_empty;
  assign io.tag_valid_o  = tag_valid_q;
  assign io.tag_o        = tag_q;
  assign io.busy_o       = busy_q;
  assign io.error_o      = error_q;

endmodule
